// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: round-robin arbiter sharing one single-port GLB SRAM bank
// between NUM_REQ requesters. Bursts lock the port until their last beat, and read
// data returns one cycle after acceptance, tagged to the requester that issued it.
module glb_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,

    // Requester side
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,

    // Read response side
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,

    // SRAM macro side
    output logic                          sram_en,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    input  logic [DATA_WIDTH-1:0]         sram_rdata
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]  rsp_pend_q, rsp_pend_d;

    logic [PtrW-1:0]     cand;
    logic [PtrW-1:0]     winner;
    logic                win_found;

    logic [PtrW-1:0]     gnt_idx;
    int unsigned         gnt_int;
    logic                accept;
    logic [PtrW-1:0]     next_ptr;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        cand      = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // Grant selection: owner while locked, search winner while idle; nothing in reset.
    always_comb begin
        req_ready = '0;
        if (state_q == StLocked) begin
            gnt_idx = owner_q;
            accept  = req_valid[owner_q];
        end else begin
            gnt_idx = winner;
            accept  = win_found;
        end
        // Outputs must read as idle while reset is held, even before the clock edge.
        if (reset) begin
            accept = 1'b0;
        end
        gnt_int = 32'(gnt_idx);
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // SRAM drive: zero-latency pass-through of the granted requester's beat.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (accept) begin
            sram_en    = 1'b1;
            sram_we    = req_we[gnt_idx];
            sram_addr  = req_addr[gnt_int*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata = req_wdata[gnt_int*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pointer advance after a finished burst, wrapping at the last requester.
    always_comb begin
        if (gnt_int == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx + 1'b1;
        end
    end

    // FSM next-state: lock on a non-last beat from idle, release on any last beat.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        rsp_pend_d = '0;
        if (accept) begin
            if (!req_we[gnt_idx]) begin
                rsp_pend_d[gnt_idx] = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_last[gnt_idx]) begin
                        rr_ptr_d = next_ptr;
                    end else begin
                        state_d = StLocked;
                        owner_d = gnt_idx;
                    end
                end
                StLocked: begin
                    if (req_last[gnt_idx]) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers; reset drops any lock and discards a pending read response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rsp_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    // Response path: tag is the registered one-hot, data comes straight from the macro.
    always_comb begin
        rsp_valid = reset ? '0 : rsp_pend_q;
        rsp_data  = sram_rdata;
    end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Scoreboard bench for glb_port_arbiter: directed per-cycle vectors push the expected
// grant/SRAM drive and read responses; a monitor pops and compares on each negedge.
module tb_glb_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 11;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              sram_en;
    logic              sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata = '0;

    logic [AW-1:0]     a  [NR];
    logic [DW-1:0]     d  [NR];
    logic [AW-1:0]     sa [NR];
    logic [DW-1:0]     sd [NR];
    logic [DW-1:0]     mem [2048];

    int cyc_n = 0;
    int applied = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [NR-1:0] rdy;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [31:0]   cyc;
    } acc_t;

    typedef struct packed {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } rsp_t;

    acc_t acc_q [$];
    rsp_t rsp_q [$];
    acc_t ea;
    rsp_t er;

    assign req_addr  = {a[3], a[2], a[1], a[0]};
    assign req_wdata = {d[3], d[2], d[1], d[0]};

    glb_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // SRAM macro model: one-cycle read latency, write visible from the next cycle.
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    // Monitor: per-cycle grant/SRAM drive check and tagged read-response check.
    always @(negedge clk) begin
        if (acc_q.size() != 0) begin
            ea = acc_q.pop_front();
            applied++;
            if (req_ready !== ea.rdy || sram_en !== ea.en || sram_we !== ea.we ||
                sram_addr !== ea.addr || sram_wdata !== ea.wd) begin
                miscompares++;
                $display("FAIL acc cyc=%0d: got rdy=%b en=%b we=%b addr=%h wd=%h, want rdy=%b en=%b we=%b addr=%h wd=%h",
                         cyc_n, req_ready, sram_en, sram_we, sram_addr, sram_wdata,
                         ea.rdy, ea.en, ea.we, ea.addr, ea.wd);
            end
        end
        if (rsp_valid !== '0) begin
            applied++;
            if (rsp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp cyc=%0d: got unexpected rsp_valid=%b data=%h, want none",
                         cyc_n, rsp_valid, rsp_data);
            end else begin
                er = rsp_q.pop_front();
                if (rsp_valid !== er.vld || rsp_data !== er.data || cyc_n != int'(er.cyc)) begin
                    miscompares++;
                    $display("FAIL rsp cyc=%0d: got vld=%b data=%h, want vld=%b data=%h at cyc=%0d",
                             cyc_n, rsp_valid, rsp_data, er.vld, er.data, er.cyc);
                end
            end
        end
    end

    task automatic stage(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        sa[i] = ad;
        sd[i] = wd;
    endtask

    // One clock of stimulus plus its hand-computed expectations.
    task automatic step(input logic rst_v, input logic [NR-1:0] sv, input logic [NR-1:0] sl,
                        input logic [NR-1:0] sw, input logic [NR-1:0] e_rdy, input logic e_en,
                        input logic e_we, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
                        input logic [NR-1:0] e_rsp, input logic [DW-1:0] e_rd);
        acc_t x;
        rsp_t r;
        @(posedge clk);
        #1;
        reset     = rst_v;
        req_valid = sv;
        req_last  = sl;
        req_we    = sw;
        for (int i = 0; i < NR; i++) begin
            a[i] = sa[i];
            d[i] = sd[i];
        end
        x = '{rdy: e_rdy, en: e_en, we: e_we, addr: e_addr, wd: e_wd, cyc: 32'(cyc_n)};
        acc_q.push_back(x);
        if (e_rsp != '0) begin
            r = '{vld: e_rsp, data: e_rd, cyc: 32'(cyc_n + 1)};
            rsp_q.push_back(r);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            a[i] = '0; d[i] = '0; sa[i] = '0; sd[i] = '0;
        end
        for (int i = 0; i < 2048; i++) mem[i] = 64'h1000 + 64'(i);

        // Reset holds every output low even with all requesters valid.
        step(1, 4'hF, 4'hF, 4'hF, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);
        step(1, 4'hF, 4'hF, 4'hF, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);

        // Single write via req0, read back via req2.
        stage(0, 11'h005, 64'hA5A5);
        step(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1, 11'h005, 64'hA5A5, 4'b0, 64'h0);
        stage(2, 11'h005, 64'h0);
        step(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 0, 11'h005, 64'h0, 4'b0100, 64'hA5A5);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);

        // Round-robin fairness after reset, including the 3 -> 0 wrap.
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);
        for (int i = 0; i < NR; i++) stage(i, 11'h100 + 11'(i), 64'hB0 + 64'(i));
        step(0, 4'hF, 4'hF, 4'hF, 4'b0001, 1, 1, 11'h100, 64'hB0, 4'b0, 64'h0);
        step(0, 4'hF, 4'hF, 4'hF, 4'b0010, 1, 1, 11'h101, 64'hB1, 4'b0, 64'h0);
        step(0, 4'hF, 4'hF, 4'hF, 4'b0100, 1, 1, 11'h102, 64'hB2, 4'b0, 64'h0);
        step(0, 4'hF, 4'hF, 4'hF, 4'b1000, 1, 1, 11'h103, 64'hB3, 4'b0, 64'h0);
        step(0, 4'hF, 4'hF, 4'hF, 4'b0001, 1, 1, 11'h100, 64'hB0, 4'b0, 64'h0);

        // 4-beat read burst on req1 against single-beat writes on req0/req3.
        stage(0, 11'h200, 64'hC0);
        stage(3, 11'h203, 64'hC3);
        stage(1, 11'h100, 64'h0);
        step(0, 4'b1011, 4'b1001, 4'b1001, 4'b0010, 1, 0, 11'h100, 64'h0, 4'b0010, 64'hB0);
        stage(1, 11'h101, 64'h0);
        step(0, 4'b1011, 4'b1001, 4'b1001, 4'b0010, 1, 0, 11'h101, 64'h0, 4'b0010, 64'hB1);
        stage(1, 11'h102, 64'h0);
        step(0, 4'b1011, 4'b1001, 4'b1001, 4'b0010, 1, 0, 11'h102, 64'h0, 4'b0010, 64'hB2);
        stage(1, 11'h103, 64'h0);
        step(0, 4'b1011, 4'b1011, 4'b1001, 4'b0010, 1, 0, 11'h103, 64'h0, 4'b0010, 64'hB3);
        step(0, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 1, 1, 11'h203, 64'hC3, 4'b0, 64'h0);
        step(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1, 11'h200, 64'hC0, 4'b0, 64'h0);

        // req2 burst stalls for three cycles; req0 must not slip in.
        stage(0, 11'h210, 64'hD0);
        stage(2, 11'h300, 64'hE0);
        step(0, 4'b0101, 4'b0001, 4'b0101, 4'b0100, 1, 1, 11'h300, 64'hE0, 4'b0, 64'h0);
        for (int i = 0; i < 3; i++)
            step(0, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);
        stage(2, 11'h301, 64'hE1);
        step(0, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 1, 1, 11'h301, 64'hE1, 4'b0, 64'h0);
        step(0, 4'b0001, 4'b0001, 4'b0101, 4'b0001, 1, 1, 11'h210, 64'hD0, 4'b0, 64'h0);
        stage(0, 11'h300, 64'hD0);
        step(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 11'h300, 64'hD0, 4'b0001, 64'hE0);

        // Reset during beat 2 of a req3 read burst: response and lock are dropped.
        stage(3, 11'h100, 64'h0);
        step(0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 0, 11'h100, 64'h0, 4'b0, 64'h0);
        stage(0, 11'h400, 64'hF0);
        stage(3, 11'h101, 64'h0);
        step(1, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);
        step(0, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 1, 1, 11'h400, 64'hF0, 4'b0, 64'h0);
        stage(3, 11'h400, 64'h0);
        step(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 0, 11'h400, 64'h0, 4'b1000, 64'hF0);

        // Back-to-back reads on req0, addresses 0..7 (address 5 holds the earlier write).
        for (int i = 0; i < 8; i++) begin
            stage(0, 11'(i), 64'h0);
            step(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 11'(i), 64'h0, 4'b0001,
                 (i == 5) ? 64'hA5A5 : 64'h1000 + 64'(i));
        end
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 11'h0, 64'h0, 4'b0, 64'h0);

        @(negedge clk);
        #1;
        applied++;
        if (rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rsp_drain: got %0d responses never delivered, want 0", rsp_q.size());
        end
        applied++;
        if (acc_q.size() != 0) begin
            miscompares++;
            $display("FAIL acc_drain: got %0d unchecked vectors, want 0", acc_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
